// File: rtl/rounding_unit_scheduler_pkg.sv
// rtl/rounding_unit_scheduler_pkg.sv - shared types and widths for the rounding-unit scheduler
package rounding_unit_pkg;

  localparam int FRACTION_IN_WIDTH  = 49;
  localparam int FRACTION_OUT_WIDTH = 32;
  localparam int EXPONENT_WIDTH     = 10;
  localparam int TAG_WIDTH          = 4;
  localparam int SRC_WIDTH          = 2;

  typedef struct packed {
    logic                         sign;
    logic [EXPONENT_WIDTH-1:0]    exponent;
    logic [FRACTION_IN_WIDTH-1:0] normalized_fraction;
    logic                         rounding_mode;
    logic [TAG_WIDTH-1:0]         tag;
  } round_req_t;

  typedef struct packed {
    logic                          sign;
    logic [EXPONENT_WIDTH-1:0]     exponent;
    logic [FRACTION_OUT_WIDTH-1:0] fraction;
    logic [TAG_WIDTH-1:0]          tag;
    logic [SRC_WIDTH-1:0]          src;
  } round_rsp_t;

endpackage

// File: rtl/rounding_unit_scheduler_if.sv
// rtl/rounding_unit_scheduler_if.sv - requester, incrementer and output bundle of the scheduler
interface rounding_unit_scheduler_if
  import rounding_unit_pkg::*;
#(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  round_req_t [NUM_REQ-1:0]      req_data;
  logic                          ru_rounding_mode;
  logic [FRACTION_IN_WIDTH-1:0]  ru_normalized_fraction;
  logic [FRACTION_OUT_WIDTH-1:0] ru_incremented_fraction;
  logic                          out_valid;
  logic                          out_ready;
  round_rsp_t                    out_data;

  modport master (
    output req_valid, req_data, ru_incremented_fraction, out_ready,
    input  req_ready, ru_rounding_mode, ru_normalized_fraction, out_valid, out_data
  );

  modport slave (
    input  req_valid, req_data, ru_incremented_fraction, out_ready,
    output req_ready, ru_rounding_mode, ru_normalized_fraction, out_valid, out_data
  );

endinterface

// File: rtl/rounding_unit_scheduler_rr_arbiter.sv
// rtl/rounding_unit_scheduler_rr_arbiter.sv - round-robin grant over requesters
// ROUNDING_SCHEDULER_FIXED_PRIORITY_EN selects lowest-index-wins with no pointer.
module rounding_unit_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

`ifdef ROUNDING_SCHEDULER_FIXED_PRIORITY_EN
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_grant_q;
  int               cand;

  // Walk offsets farthest-first so the nearest requester after last_grant_q wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(last_grant_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req_i[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else if (en_i && pick_found) begin
      last_grant_q <= pick_idx;
    end
  end
`endif

  assign any_o   = en_i & pick_found;
  assign idx_o   = pick_idx;
  assign grant_o = any_o ? (NUM_REQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/rounding_unit_scheduler.sv
// rtl/rounding_unit_scheduler.sv - shares one rounding incrementer across FPU pipes
// Issue stage S1 feeds the external incrementer; S2 captures its result for writeback.
module rounding_unit_scheduler
  import rounding_unit_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  rounding_unit_scheduler_if.slave  bus
);

  logic                 s1_valid_q, s1_valid_d;
  round_req_t           s1_req_q, s1_req_d;
  logic [SRC_WIDTH-1:0] s1_src_q, s1_src_d;
  logic                 s2_valid_q, s2_valid_d;
  round_rsp_t           s2_rsp_q, s2_rsp_d;

  logic                 adv1, adv2;
  logic [NUM_REQ-1:0]   grant;
  logic [SRC_WIDTH-1:0] grant_idx;
  logic                 grant_any;

  assign adv2 = !s2_valid_q || bus.out_ready;
  assign adv1 = !s1_valid_q || adv2;

  // Gating with reset_n keeps req_ready low for the whole reset window.
  rounding_unit_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_WIDTH)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (bus.req_valid),
    .en_i    (adv1 & reset_n),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign bus.req_ready = grant;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_req_d   = s1_req_q;
    s1_src_d   = s1_src_q;
    s2_valid_d = s2_valid_q;
    s2_rsp_d   = s2_rsp_q;
    if (adv1) begin
      s1_valid_d = grant_any;
      if (grant_any) begin
        s1_req_d = bus.req_data[grant_idx];
        s1_src_d = grant_idx;
      end
    end
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_rsp_d = '{sign:     s1_req_q.sign,
                     exponent: s1_req_q.exponent,
                     fraction: bus.ru_incremented_fraction,
                     tag:      s1_req_q.tag,
                     src:      s1_src_q};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_req_q   <= '0;
      s1_src_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_rsp_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_req_q   <= s1_req_d;
      s1_src_q   <= s1_src_d;
      s2_valid_q <= s2_valid_d;
      s2_rsp_q   <= s2_rsp_d;
    end
  end

  assign bus.ru_rounding_mode       = s1_valid_q & s1_req_q.rounding_mode;
  assign bus.ru_normalized_fraction = s1_valid_q ? s1_req_q.normalized_fraction : '0;
  assign bus.out_valid              = s2_valid_q;
  assign bus.out_data               = s2_rsp_q;

endmodule

// File: tb/tb_rounding_unit_scheduler.sv
// tb/tb_rounding_unit_scheduler.sv - directed bench with scoreboard for rounding_unit_scheduler
module tb_rounding_unit_scheduler;
  import rounding_unit_pkg::*;

  localparam int NUM_REQ = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rounding_unit_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  rounding_unit_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Incrementer stand-in: top 32 bits of the 49-bit fraction plus the round bit.
  assign bus.ru_incremented_fraction = bus.ru_normalized_fraction[48:17] + {31'b0, bus.ru_rounding_mode};

  int         checks = 0;
  int         failures = 0;
  round_rsp_t sb[$];
  logic       m_s1, m_s2;
  int         m_ptr;
  logic [3:0] tag_ctr = 4'd6;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_pick(input logic [NUM_REQ-1:0] v, input int ptr);
`ifdef ROUNDING_SCHEDULER_FIXED_PRIORITY_EN
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (ptr + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
`endif
  endfunction

  function automatic round_req_t rand_req(input logic [3:0] tag);
    round_req_t r;
    r                     = '0;
    r.sign                = 1'($urandom);
    r.exponent            = 10'($urandom);
    r.normalized_fraction = {17'($urandom), $urandom};
    r.rounding_mode       = 1'($urandom);
    r.tag                 = tag;
    return r;
  endfunction

  // Pipeline model plus scoreboard, evaluated once per cycle away from the clock edge.
  always @(negedge clk) begin : mon
    logic       a1, a2;
    int         p;
    logic [1:0] pi;
    round_req_t rq;
    round_rsp_t got;
    if (!reset_n) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      m_ptr = NUM_REQ - 1;
      sb.delete();
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    end else begin
      a2 = !m_s2 || bus.out_ready;
      a1 = !m_s1 || a2;
      p  = a1 ? exp_pick(bus.req_valid, m_ptr) : -1;
      chk("req_ready", 64'(bus.req_ready), (p >= 0) ? (64'd1 << p) : 64'd0);
      chk("out_valid", 64'(bus.out_valid), 64'(m_s2));
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(got));
        end
      end
      if (a2) m_s2 = m_s1;
      if (a1) m_s1 = (p >= 0);
      if (p >= 0) begin
        pi = 2'(p);
        rq = bus.req_data[pi];
        sb.push_back('{sign: rq.sign, exponent: rq.exponent,
                       fraction: rq.normalized_fraction[48:17] + {31'b0, rq.rounding_mode},
                       tag: rq.tag, src: pi});
        m_ptr = p;
      end
    end
  end

  task automatic next_cycle_refresh();
    logic [NUM_REQ-1:0] acc;
    acc = bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        bus.req_data[i] = rand_req(tag_ctr);
        tag_ctr = tag_ctr + 4'd1;
      end
    end
  endtask

  initial begin
    round_req_t single;
    round_rsp_t held;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    single = '{sign: 1'b1, exponent: 10'h155, normalized_fraction: 49'h1_0000_0002_0000,
               rounding_mode: 1'b1, tag: 4'd5};
    bus.req_data[0] = single;
    bus.req_valid   = 3'b001;

    // Reset state, with a request already pending
    repeat (2) @(negedge clk);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_ru_frac", 64'(bus.ru_normalized_fraction), 64'd0);
    chk("rst_ru_mode", 64'(bus.ru_rounding_mode), 64'd0);
    chk("rst_ready_held", 64'(bus.req_ready), 64'd0);

    // Single op: accept cycle 0, result cycle 2
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("single_accept", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_c1_valid", 64'(bus.out_valid), 64'd0);
    chk("single_ru_frac", 64'(bus.ru_normalized_fraction), 64'h1_0000_0002_0000);
    chk("single_ru_mode", 64'(bus.ru_rounding_mode), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_c2_valid", 64'(bus.out_valid), 64'd1);
    chk("single_frac", 64'(bus.out_data.fraction), 64'h8000_0002);
    chk("single_tag", 64'(bus.out_data.tag), 64'd5);
    chk("single_src", 64'(bus.out_data.src), 64'd0);
    chk("single_exp", 64'(bus.out_data.exponent), 64'h155);
    chk("single_sign", 64'(bus.out_data.sign), 64'd1);

    // All three valid, full throughput
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_data[i] = rand_req(tag_ctr);
      tag_ctr = tag_ctr + 4'd1;
    end
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifndef ROUNDING_SCHEDULER_FIXED_PRIORITY_EN
      chk("rr_seq", 64'(bus.req_ready), 64'd1 << ((1 + k) % NUM_REQ));
`endif
      next_cycle_refresh();
    end

    // Output stall with the stream active
    bus.out_ready = 1'b0;
    @(negedge clk);
    held = bus.out_data;
    next_cycle_refresh();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_ready", 64'(bus.req_ready), 64'd0);
      chk("stall_hold", 64'(bus.out_data), 64'(held));
      next_cycle_refresh();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      next_cycle_refresh();
    end

    // Lone requester 2 keeps winning
    bus.req_valid = 3'b100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lone_req2", 64'(bus.req_ready), 64'd4);
      next_cycle_refresh();
    end

    // Reset mid-flight with both stages full
    bus.req_valid = 3'b111;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      next_cycle_refresh();
    end
    @(negedge clk);
    chk("pre_rst_full", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_ru_frac", 64'(bus.ru_normalized_fraction), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 64'(bus.req_ready), 64'd1);
    chk("post_rst_no_out", 64'(bus.out_valid), 64'd0);
    next_cycle_refresh();
    @(negedge clk);
    chk("post_rst_no_out2", 64'(bus.out_valid), 64'd0);
    next_cycle_refresh();

`ifdef ROUNDING_SCHEDULER_FIXED_PRIORITY_EN
    bus.req_valid = 3'b101;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("fixed_req0", 64'(bus.req_ready), 64'd1);
      next_cycle_refresh();
    end
`endif

    // Drain and confirm nothing was lost
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      next_cycle_refresh();
    end
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
